// File: rtl/icache_assoc_if.sv
// ----------------------------------------------------------------------------
// icache_assoc_if
// Fetch-side and memory-side signal bundle of the 2-way instruction cache.
//   slave  : the cache view (takes CPU requests, drives the memory request)
//   master : the environment view (CPU fetch stage plus instruction memory)
// Signals:
//   cpu_read, cpu_address, cpu_flush      : fetch request, address, flush
//   cpu_instruction, cpu_busywait         : fetched word, CPU stall
//   mem_read, mem_address                 : block read request, {tag,index}
//   mem_instruction, mem_busywait         : returned block, memory busy
// ----------------------------------------------------------------------------
interface icache_assoc_if #(
   parameter int ADDR_W   = 10,
   parameter int INDEX_W  = 3,
   parameter int OFFSET_W = 2,
   parameter int WORD_W   = 32
);
   localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W - 2;
   localparam int BLOCK_W    = WORD_W << OFFSET_W;
   localparam int MEM_ADDR_W = TAG_W + INDEX_W;

   logic                  cpu_read;
   logic [ADDR_W-1:0]     cpu_address;
   logic                  cpu_flush;
   logic [WORD_W-1:0]     cpu_instruction;
   logic                  cpu_busywait;
   logic                  mem_read;
   logic [MEM_ADDR_W-1:0] mem_address;
   logic [BLOCK_W-1:0]    mem_instruction;
   logic                  mem_busywait;

   modport slave (
      input  cpu_read, cpu_address, cpu_flush, mem_instruction, mem_busywait,
      output cpu_instruction, cpu_busywait, mem_read, mem_address
   );

   modport master (
      output cpu_read, cpu_address, cpu_flush, mem_instruction, mem_busywait,
      input  cpu_instruction, cpu_busywait, mem_read, mem_address
   );
endinterface

// File: rtl/icache_assoc.sv
// ----------------------------------------------------------------------------
// icache_assoc
// 2-way set-associative read-only instruction cache with LRU replacement and
// full flush. Hits return the word combinationally in the request cycle; a
// miss runs a block refill through an IDLE -> MEM_READ -> UPDATE controller.
// Ports:
//   clock  : system clock
//   reset  : asynchronous, active-high
//   bus    : icache_assoc_if.slave (CPU fetch side and memory side)
// Optional build macro ICACHE_PERF_CNT_EN adds:
//   hit_count, miss_count : 16-bit saturating hit / miss counters
// ----------------------------------------------------------------------------
module icache_assoc #(
   parameter int ADDR_W   = 10,
   parameter int INDEX_W  = 3,
   parameter int OFFSET_W = 2,
   parameter int WORD_W   = 32
) (
   input  logic            clock,
   input  logic            reset,
   icache_assoc_if.slave   bus
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [15:0]     hit_count,
   output logic [15:0]     miss_count
`endif
);
   localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W - 2;
   localparam int BLOCK_W    = WORD_W << OFFSET_W;
   localparam int MEM_ADDR_W = TAG_W + INDEX_W;
   localparam int SETS       = 1 << INDEX_W;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      UPDATE   = 2'd2
   } state_t;

   state_t                  state_r, state_s;
   logic [SETS-1:0][1:0]    valid_r;
   logic [SETS-1:0]         lru_r;
   logic [TAG_W-1:0]        tag_r   [SETS][2];
   logic [BLOCK_W-1:0]      block_r [SETS][2];
   logic [TAG_W-1:0]        req_tag_r;
   logic [INDEX_W-1:0]      req_index_r;
   logic                    seen_busy_r;
   logic                    flush_pending_r;

   logic [TAG_W-1:0]        tag_s;
   logic [INDEX_W-1:0]      index_s;
   logic [OFFSET_W-1:0]     offset_s;
   logic                    hit0_s, hit1_s, hit_s;
   logic                    victim_s;
   logic                    fill_s;
   logic                    flush_clear_s;
   logic                    unused_s;

   assign tag_s    = bus.cpu_address[ADDR_W-1 -: TAG_W];
   assign index_s  = bus.cpu_address[OFFSET_W+2 +: INDEX_W];
   assign offset_s = bus.cpu_address[2 +: OFFSET_W];
   assign unused_s = ^bus.cpu_address[1:0];

   assign hit0_s = valid_r[index_s][0] && (tag_r[index_s][0] == tag_s);
   assign hit1_s = valid_r[index_s][1] && (tag_r[index_s][1] == tag_s);
   assign hit_s  = hit0_s || hit1_s;

   // Victim for the pending refill: first empty way (way 0 first), else LRU.
   assign victim_s = !valid_r[req_index_r][0] ? 1'b0 :
                     (!valid_r[req_index_r][1] ? 1'b1 : lru_r[req_index_r]);

   assign bus.cpu_busywait = (bus.cpu_read && !hit_s) || (state_r != IDLE);

   // Word selection from the hitting way.
   always_comb begin
      bus.cpu_instruction = {WORD_W{1'b0}};
      if (hit0_s) begin
         bus.cpu_instruction = block_r[index_s][0][offset_s*WORD_W +: WORD_W];
      end else if (hit1_s) begin
         bus.cpu_instruction = block_r[index_s][1][offset_s*WORD_W +: WORD_W];
      end else begin
         bus.cpu_instruction = {WORD_W{1'b0}};
      end
   end

   // Edges that wipe all valid/lru bits: an IDLE flush, or the UPDATE exit
   // carrying a flush that arrived during the refill.
   always_comb begin
      flush_clear_s = 1'b0;
      if (state_r == IDLE) begin
         flush_clear_s = bus.cpu_flush;
      end else if (state_r == UPDATE) begin
         flush_clear_s = flush_pending_r || bus.cpu_flush;
      end else begin
         flush_clear_s = 1'b0;
      end
   end

   // Refill controller next state and memory request outputs.
   always_comb begin
      state_s         = state_r;
      bus.mem_read    = 1'b0;
      bus.mem_address = {MEM_ADDR_W{1'b0}};
      fill_s          = 1'b0;
      case (state_r)
         IDLE: begin
            // A flush takes priority; the miss is taken on the following edge.
            if (bus.cpu_read && !hit_s && !bus.cpu_flush) begin
               state_s = MEM_READ;
            end else begin
               state_s = IDLE;
            end
         end
         MEM_READ: begin
            bus.mem_read    = 1'b1;
            bus.mem_address = {req_tag_r, req_index_r};
            // Busy must have been seen first so a stale idle bus is not sampled.
            if (seen_busy_r && !bus.mem_busywait) begin
               fill_s  = 1'b1;
               state_s = UPDATE;
            end else begin
               state_s = MEM_READ;
            end
         end
         UPDATE:  state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Valid/LRU bookkeeping, request latch and refill handshake flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_r         <= {(2*SETS){1'b0}};
         lru_r           <= {SETS{1'b0}};
         req_tag_r       <= {TAG_W{1'b0}};
         req_index_r     <= {INDEX_W{1'b0}};
         seen_busy_r     <= 1'b0;
         flush_pending_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               seen_busy_r <= 1'b0;
               if (flush_clear_s) begin
                  valid_r <= {(2*SETS){1'b0}};
                  lru_r   <= {SETS{1'b0}};
               end else if (bus.cpu_read && hit_s) begin
                  // Way 0 hit makes way 1 the next victim and vice versa.
                  lru_r[index_s] <= hit0_s;
               end else if (bus.cpu_read) begin
                  req_tag_r   <= tag_s;
                  req_index_r <= index_s;
               end
            end
            MEM_READ: begin
               if (bus.mem_busywait) begin
                  seen_busy_r <= 1'b1;
               end
               if (bus.cpu_flush) begin
                  flush_pending_r <= 1'b1;
               end
               if (fill_s) begin
                  valid_r[req_index_r][victim_s] <= 1'b1;
                  lru_r[req_index_r]             <= ~victim_s;
               end
            end
            UPDATE: begin
               seen_busy_r     <= 1'b0;
               flush_pending_r <= 1'b0;
               if (flush_clear_s) begin
                  valid_r <= {(2*SETS){1'b0}};
                  lru_r   <= {SETS{1'b0}};
               end
            end
            default: begin
               seen_busy_r     <= 1'b0;
               flush_pending_r <= 1'b0;
            end
         endcase
      end
   end

   // Tag and data arrays; contents are qualified by valid_r so need no reset.
   always_ff @(posedge clock) begin
      if (fill_s) begin
         tag_r[req_index_r][victim_s]   <= req_tag_r;
         block_r[req_index_r][victim_s] <= bus.mem_instruction;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   // Saturating hit/miss counters, cleared together with the cache contents.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_count  <= 16'h0000;
         miss_count <= 16'h0000;
      end else if (flush_clear_s) begin
         hit_count  <= 16'h0000;
         miss_count <= 16'h0000;
      end else begin
         if ((state_r == IDLE) && bus.cpu_read && hit_s && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'h0001;
         end
         if ((state_r == IDLE) && (state_s == MEM_READ) && (miss_count != 16'hFFFF)) begin
            miss_count <= miss_count + 16'h0001;
         end
      end
   end
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// ----------------------------------------------------------------------------
// tb_icache_assoc
// Directed bench for icache_assoc with a behavioural instruction memory whose
// latency and busy-start delay are adjustable. Expected words are queued when
// a fetch is issued and popped when the cache releases busywait.
// ----------------------------------------------------------------------------
module tb_icache_assoc;
   localparam int ADDR_W     = 10;
   localparam int INDEX_W    = 3;
   localparam int OFFSET_W   = 2;
   localparam int WORD_W     = 32;
   localparam int BLOCK_W    = 128;
   localparam int MEM_ADDR_W = 6;

   logic clock;
   logic reset;

   icache_assoc_if #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .WORD_W(WORD_W)) bus ();

`ifdef ICACHE_PERF_CNT_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   icache_assoc #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .WORD_W(WORD_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   int n_checks  = 0;
   int n_fails   = 0;
   int mem_lat   = 2;
   int mem_delay = 0;
   logic [WORD_W-1:0]  exp_q [$];
   logic [BLOCK_W-1:0] garbage_blk = {4{32'hBAD0_BAD0}};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [WORD_W-1:0] model_word(input logic [MEM_ADDR_W-1:0] blk, input int w);
      return {16'hC0DE, 2'b00, blk, 6'b000000, w[1:0]};
   endfunction

   function automatic logic [BLOCK_W-1:0] model_block(input logic [MEM_ADDR_W-1:0] blk);
      logic [BLOCK_W-1:0] b;
      b = {BLOCK_W{1'b0}};
      for (int w = 0; w < 4; w++) b[w*WORD_W +: WORD_W] = model_word(blk, w);
      return b;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Instruction memory: busy for mem_lat edges after mem_delay edges, then data.
   initial begin
      bit active;
      int mcnt;
      active = 1'b0;
      mcnt   = 0;
      bus.mem_busywait    = 1'b0;
      bus.mem_instruction = garbage_blk;
      forever begin
         @(posedge clock);
         #1;
         if (reset || !bus.mem_read) begin
            active              = 1'b0;
            bus.mem_busywait    = 1'b0;
            bus.mem_instruction = garbage_blk;
         end else begin
            if (!active) begin
               active = 1'b1;
               mcnt   = 0;
            end else begin
               mcnt++;
            end
            bus.mem_busywait    = (mcnt >= mem_delay) && (mcnt < mem_delay + mem_lat);
            bus.mem_instruction = (mcnt >= mem_delay + mem_lat) ? model_block(bus.mem_address) : garbage_blk;
         end
      end
   end

   // One fetch: queue the expected word, count busy cycles, compare on release.
   task automatic fetch(input string tag, input logic [ADDR_W-1:0] addr, input int exp_busy, input bit flush_mid);
      int busy;
      bit saw_read;
      bit flushed;
      logic [MEM_ADDR_W-1:0] blk;
      logic [MEM_ADDR_W-1:0] seen_addr;
      blk       = addr[9:4];
      busy      = 0;
      saw_read  = 1'b0;
      flushed   = 1'b0;
      seen_addr = {MEM_ADDR_W{1'b0}};
      @(posedge clock);
      #1;
      exp_q.push_back(model_word(blk, int'(addr[3:2])));
      bus.cpu_address = addr;
      bus.cpu_read    = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (bus.cpu_flush) bus.cpu_flush = 1'b0;
         if (!bus.cpu_busywait) break;
         busy++;
         if (bus.mem_read && !saw_read) begin
            saw_read  = 1'b1;
            seen_addr = bus.mem_address;
            if (flush_mid && !flushed) begin
               bus.cpu_flush = 1'b1;
               flushed       = 1'b1;
            end
         end
      end
      check({tag, " busy cycles"}, 32'(busy), 32'(exp_busy));
      if (exp_busy > 0) check({tag, " mem_address"}, 32'(seen_addr), 32'(blk));
      else              check({tag, " mem_read seen"}, 32'(saw_read), 32'd0);
      check({tag, " word"}, bus.cpu_instruction, exp_q.pop_front());
      @(posedge clock);
      #1;
      bus.cpu_read = 1'b0;
   endtask

   initial begin
      reset           = 1'b1;
      bus.cpu_read    = 1'b0;
      bus.cpu_address = {ADDR_W{1'b0}};
      bus.cpu_flush   = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      bus.cpu_read = 1'b1;
      #1;
      check("reset mem_read", 32'(bus.mem_read), 32'd0);
      check("reset mem_address", 32'(bus.mem_address), 32'd0);
      check("reset cpu_instruction", bus.cpu_instruction, 32'd0);
      check("reset busywait follows read", 32'(bus.cpu_busywait), 32'd1);
      bus.cpu_read = 1'b0;
      #1;
      check("reset busywait idle", 32'(bus.cpu_busywait), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Cold miss, same-block hits, LRU eviction in set 0.
      fetch("cold 0x000", 10'h000, 5, 1'b0);
      fetch("hit 0x004", 10'h004, 0, 1'b0);
      fetch("hit 0x00C", 10'h00C, 0, 1'b0);
      fetch("fill 0x080", 10'h080, 5, 1'b0);
      fetch("hit 0x000", 10'h000, 0, 1'b0);
      fetch("evict 0x100", 10'h100, 5, 1'b0);
      fetch("kept 0x000", 10'h000, 0, 1'b0);
      fetch("hit 0x108", 10'h108, 0, 1'b0);
      fetch("evicted 0x080", 10'h080, 5, 1'b0);

      // 1-cycle memory gives the minimum 4-cycle penalty.
      mem_lat = 1;
      fetch("lat1 0x3F4", 10'h3F4, 4, 1'b0);
      mem_lat = 2;

      // Idle bus before busy must not be taken as the refill data.
      mem_delay = 1;
      fetch("stale 0x050", 10'h050, 6, 1'b0);
      mem_delay = 0;

      // Flush in IDLE, then flush during MEM_READ forces a second refill.
      @(posedge clock);
      #1;
      bus.cpu_flush = 1'b1;
      @(posedge clock);
      #1;
      bus.cpu_flush = 1'b0;
      fetch("post-flush 0x000", 10'h000, 5, 1'b0);
      fetch("flush mid 0x020", 10'h020, 10, 1'b1);

      // Reset in the middle of a refill.
      @(posedge clock);
      #1;
      bus.cpu_address = 10'h060;
      bus.cpu_read    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.mem_read) break;
      end
      check("midrst mem_read before", 32'(bus.mem_read), 32'd1);
      reset = 1'b1;
      #1;
      check("midrst mem_read drop", 32'(bus.mem_read), 32'd0);
      check("midrst busywait", 32'(bus.cpu_busywait), 32'd1);
      check("midrst mem_address", 32'(bus.mem_address), 32'd0);
      bus.cpu_read = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      fetch("retry 0x060", 10'h060, 5, 1'b0);
      fetch("cold again 0x000", 10'h000, 5, 1'b0);

`ifdef ICACHE_PERF_CNT_EN
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("perf reset hit", 32'(hit_count), 32'd0);
      check("perf reset miss", 32'(miss_count), 32'd0);
      fetch("perf 0x000", 10'h000, 5, 1'b0);
      fetch("perf 0x004", 10'h004, 0, 1'b0);
      fetch("perf 0x080", 10'h080, 5, 1'b0);
      fetch("perf 0x084", 10'h084, 0, 1'b0);
      fetch("perf 0x3F0", 10'h3F0, 5, 1'b0);
      check("perf miss_count", 32'(miss_count), 32'd3);
      check("perf hit_count", 32'(hit_count), 32'd5);
      @(posedge clock);
      #1;
      bus.cpu_flush = 1'b1;
      @(posedge clock);
      #1;
      bus.cpu_flush = 1'b0;
      check("perf flush hit", 32'(hit_count), 32'd0);
      check("perf flush miss", 32'(miss_count), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
